bkram_sd_ctrl: RTL and testbench
================================

Name: bkram_sd_ctrl

Overview:
- Sequencer that moves cartridge backup RAM (BSRAM) to and from the mounted save image over the sector-based sd_lba / sd_rd / sd_wr / sd_ack handshake.
- Generalises the fixed 512-byte, manual-only load/save logic with:
  - parametrised sector size and maximum image size;
  - ack timeout with sticky error;
  - dirty tracking and idle-triggered autosave;
  - post-download autoload.
- Sits between hps_io and the BSRAM dual-port RAM. Its `loading` output holds the core in reset while a load runs.

Parameters:
- LBA_W, 32: width of sd_lba.
- SECTOR_BITS, 9: log2 bytes per sector.
- MAX_SECT_BITS, 7: log2 of the maximum sector count (default 128 sectors = 64 KB).
- ACK_TIMEOUT, 50000000: clk_sys cycles to wait for an sd_ack rising edge before aborting. 0 disables the timeout.
- AUTOSAVE_IDLE, 100000000: clk_sys cycles without a dirty_wr pulse before an autosave starts.

Ports:
- clk_sys  in  1  system clock
- reset  in  1  synchronous, active-low reset
- ram_mask  in  24  BSRAM byte mask; 0 = no backup RAM
- enable  in  1  save image mounted and writable
- load_req  in  1  level; its rising edge requests a load
- save_req  in  1  level; its rising edge requests a save
- autoload  in  1  one-cycle pulse at the end of ROM download
- autosave_en  in  1  enables autosave
- dirty_wr  in  1  one-cycle pulse on every core write to BSRAM
- sd_ack  in  1  hps_io sector acknowledge
- sd_lba  out  LBA_W  current sector
- sd_rd  out  1  sector read request
- sd_wr  out  1  sector write request
- loading  out  1  a load is in progress
- busy  out  1  any transfer is in progress
- dirty  out  1  BSRAM has changed since the last save or load
- done  out  1  one-cycle pulse on successful completion
- error  out  1  sticky timeout flag

Behaviour:
- Reset (reset == 0):
  - All outputs are 0, sd_lba is 0, FSM is in IDLE.
  - Internal edge detectors are loaded with the current input levels, so no request fires on reset release.
- Edge detection: a registered old_load / old_save copy of each request input is taken every cycle. Request edges are qualified by `enable`.
- last_sector:
  - Computed as min(ram_mask[23:SECTOR_BITS], 2^MAX_SECT_BITS - 1).
  - Sampled into a register when a transfer starts.
  - Changes to ram_mask mid-transfer are ignored.
- Start conditions, evaluated in IDLE only:
  - Valid starts require enable == 1 and ram_mask != 0.
  - Priority: autoload > load edge > save edge > autosave.
  - Requests arriving when not in IDLE are dropped. Autosave is not lost, because dirty stays set and it retriggers.
- On an accepted start:
  - sd_lba is set to 0, busy is set to 1, and error is cleared.
  - A load sets loading = 1 and sd_rd = 1.
  - A save sets sd_wr = 1 and clears dirty.
  - The FSM enters WAIT_ACK.
- WAIT_ACK:
  - On the sd_ack rising edge, clear sd_rd and sd_wr, then go to XFER.
  - The timeout counter increments every cycle while in this state.
  - If the counter reaches ACK_TIMEOUT:
    - clear sd_rd, sd_wr, busy and loading, and set error = 1;
    - if the aborted transfer was a save, set dirty = 1;
    - go to IDLE.
- XFER: on the sd_ack falling edge:
  - If sd_lba >= last_sector, go to DONE.
  - Otherwise increment sd_lba, re-assert sd_rd for a load or sd_wr for a save, reset the timeout counter, and go to WAIT_ACK.
- DONE, which lasts one cycle:
  - Pulse done = 1 and clear busy and loading.
  - A completed load clears dirty.
  - Return to IDLE.
- Dirty tracking:
  - A dirty_wr pulse sets dirty in any state, including during a save, so the next autosave picks up the change.
  - If a dirty_wr pulse coincides with the save-start cycle, dirty ends up 1 (set wins).
  - dirty_wr during a load is ignored, because the core is held in reset.
- Autosave idle counter:
  - Resets to 0 on dirty_wr or whenever busy is 1.
  - Otherwise it increments, saturating at AUTOSAVE_IDLE.
  - An autosave triggers when autosave_en & dirty & enable & counter == AUTOSAVE_IDLE in IDLE.
- sd_lba arithmetic:
  - Held to MAX_SECT_BITS significant bits.
  - Upper bits are zero-extended to LBA_W.
  - No wrap occurs, because termination uses >=.
- If reset is asserted mid-transfer, everything returns to reset values immediately and sd_rd / sd_wr drop in that cycle.

Test Plan:
- Manual save: ram_mask = 0x001FFF, enable = 1, save_req rising edge; the bench acks each sector with 3 cycles high and 2 cycles low.
  - Required: sd_wr is asserted for sd_lba 0..15 (16 sectors), clearing on each ack rise.
  - Required: exactly one done pulse, busy falls together with it, and dirty = 0.
- Autoload plus a simultaneous load edge: autoload pulse and load_req rising edge in the same cycle, ram_mask = 0x0007FF.
  - Required: a single load of sectors 0..3 with loading = 1 throughout.
  - Required: the load edge is consumed (no second load), and loading = 0 in the done-pulse cycle.
- Timeout: ACK_TIMEOUT = 100, save started with sd_ack held at 0.
  - Required: in the 100th cycle after the start, sd_wr = 0, busy = 0, error = 1 and dirty = 1.
  - Required: a following successful load clears error at its start.
- Autosave: AUTOSAVE_IDLE = 50, autosave_en = 1, one dirty_wr pulse, then a second pulse 20 cycles later.
  - Required: the save starts exactly 50 idle cycles after the second pulse.
  - A dirty_wr pulse injected during the save leaves dirty = 1 after done.
- Boundary masks:
  - ram_mask = 0: a save_req edge produces no activity.
  - ram_mask = 0xFFFFFF with MAX_SECT_BITS = 7: the last sector is 127.
  - enable = 0: all requests are ignored.
- Mid-transfer reset: reset = 0 at sector 5 of a load.
  - Required: next cycle sd_rd = 0, loading = 0, sd_lba = 0.
  - Required: holding load_req high through reset release does not start a new load.

Source files
------------

// File: rtl/bkram_sd_ctrl_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// bkram_sd_ctrl_if : request/status and sector-handshake bundle of the BSRAM
//                    save-image sequencer.  Rev 1.0
// ---------------------------------------------------------------------------
interface bkram_sd_ctrl_if #(
  parameter int LBA_W = 32
);
  logic [23:0]      ram_mask;
  logic             enable;
  logic             load_req;
  logic             save_req;
  logic             autoload;
  logic             autosave_en;
  logic             dirty_wr;
  logic             sd_ack;
  logic [LBA_W-1:0] sd_lba;
  logic             sd_rd;
  logic             sd_wr;
  logic             loading;
  logic             busy;
  logic             dirty;
  logic             done;
  logic             error;

  modport master (
    input  ram_mask, enable, load_req, save_req, autoload, autosave_en,
           dirty_wr, sd_ack,
    output sd_lba, sd_rd, sd_wr, loading, busy, dirty, done, error
  );

  modport slave (
    output ram_mask, enable, load_req, save_req, autoload, autosave_en,
           dirty_wr, sd_ack,
    input  sd_lba, sd_rd, sd_wr, loading, busy, dirty, done, error
  );
endinterface
`default_nettype wire

// File: rtl/bkram_sd_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// bkram_sd_ctrl : moves backup RAM to/from the save image sector by sector,
//                 with ack timeout, dirty tracking, autosave and autoload.
// Rev 1.0
// ---------------------------------------------------------------------------
module bkram_sd_ctrl #(
  parameter int LBA_W         = 32,
  parameter int SECTOR_BITS   = 9,
  parameter int MAX_SECT_BITS = 7,
  parameter int ACK_TIMEOUT   = 50000000,
  parameter int AUTOSAVE_IDLE = 100000000
) (
  input  logic            clk_sys,
  input  logic            reset,
  bkram_sd_ctrl_if.master bus
);

  localparam int MASK_W = 24 - SECTOR_BITS;
  localparam int TO_W   = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT + 1) : 1;
  localparam int ID_W   = (AUTOSAVE_IDLE > 1) ? $clog2(AUTOSAVE_IDLE + 1) : 1;
  localparam logic [MASK_W-1:0] LAST_CAP = MASK_W'((1 << MAX_SECT_BITS) - 1);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_WAIT_ACK = 2'd1,
    S_XFER     = 2'd2,
    S_DONE     = 2'd3
  } state_t;

  state_t                   state_q, state_d;
  logic [MAX_SECT_BITS-1:0] lba_q, lba_d;
  logic [MAX_SECT_BITS-1:0] last_q, last_d;
  logic                     rd_q, rd_d;
  logic                     wr_q, wr_d;
  logic                     loading_q, loading_d;
  logic                     busy_q, busy_d;
  logic                     dirty_q, dirty_d;
  logic                     done_q, done_d;
  logic                     error_q, error_d;
  logic                     is_load_q, is_load_d;
  logic [TO_W-1:0]          to_cnt_q, to_cnt_d;
  logic [ID_W-1:0]          idle_cnt_q, idle_cnt_d;
  logic                     old_load_q, old_save_q, old_ack_q;

  logic [MASK_W-1:0]        mask_sect;
  logic [MAX_SECT_BITS-1:0] last_calc;
  logic [TO_W-1:0]          to_inc;
  logic                     start_ok, start_load, start_save;
  logic                     load_edge, save_edge, autosave_due;
  logic                     ack_rise, ack_fall, timeout_hit;

  assign mask_sect = bus.ram_mask[23:SECTOR_BITS];
  assign last_calc = (mask_sect > LAST_CAP) ? MAX_SECT_BITS'(LAST_CAP)
                                            : MAX_SECT_BITS'(mask_sect);

  assign start_ok     = bus.enable && (|bus.ram_mask);
  assign load_edge    = bus.load_req && !old_load_q;
  assign save_edge    = bus.save_req && !old_save_q;
  assign autosave_due = bus.autosave_en && dirty_q
                        && (idle_cnt_q == ID_W'(AUTOSAVE_IDLE));
  assign start_load   = start_ok && (bus.autoload || load_edge);
  assign start_save   = start_ok && !start_load && (save_edge || autosave_due);

  assign ack_rise     = bus.sd_ack && !old_ack_q;
  assign ack_fall     = !bus.sd_ack && old_ack_q;
  assign to_inc       = to_cnt_q + 1'b1;
  assign timeout_hit  = (ACK_TIMEOUT != 0) && (to_inc == TO_W'(ACK_TIMEOUT));

  always_comb begin
    state_d    = state_q;
    lba_d      = lba_q;
    last_d     = last_q;
    rd_d       = rd_q;
    wr_d       = wr_q;
    loading_d  = loading_q;
    busy_d     = busy_q;
    dirty_d    = dirty_q;
    done_d     = 1'b0;
    error_d    = error_q;
    is_load_d  = is_load_q;
    to_cnt_d   = to_cnt_q;
    idle_cnt_d = idle_cnt_q;

    case (state_q)
      S_IDLE: begin
        if (start_load || start_save) begin
          lba_d     = '0;
          last_d    = last_calc;
          busy_d    = 1'b1;
          error_d   = 1'b0;
          is_load_d = start_load;
          to_cnt_d  = '0;
          state_d   = S_WAIT_ACK;
          if (start_load) begin
            loading_d = 1'b1;
            rd_d      = 1'b1;
          end else begin
            wr_d      = 1'b1;
            dirty_d   = 1'b0;
          end
        end
      end
      S_WAIT_ACK: begin
        if (ack_rise) begin
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          state_d = S_XFER;
        end else if (timeout_hit) begin
          rd_d      = 1'b0;
          wr_d      = 1'b0;
          busy_d    = 1'b0;
          loading_d = 1'b0;
          error_d   = 1'b1;
          // An aborted save leaves the image stale, so the data is still unsaved
          if (!is_load_q) dirty_d = 1'b1;
          state_d   = S_IDLE;
        end else if (ACK_TIMEOUT != 0) begin
          to_cnt_d = to_inc;
        end
      end
      S_XFER: begin
        if (ack_fall) begin
          if (lba_q >= last_q) begin
            state_d = S_DONE;
          end else begin
            lba_d    = lba_q + 1'b1;
            rd_d     = is_load_q;
            wr_d     = !is_load_q;
            to_cnt_d = '0;
            state_d  = S_WAIT_ACK;
          end
        end
      end
      S_DONE: begin
        done_d    = 1'b1;
        busy_d    = 1'b0;
        loading_d = 1'b0;
        if (is_load_q) dirty_d = 1'b0;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Core writes are ignored while a load holds the core in reset; otherwise set wins
    if (bus.dirty_wr && !loading_q) dirty_d = 1'b1;

    if (bus.dirty_wr || busy_q)
      idle_cnt_d = '0;
    else if (idle_cnt_q != ID_W'(AUTOSAVE_IDLE))
      idle_cnt_d = idle_cnt_q + 1'b1;
  end

  always_ff @(posedge clk_sys) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      lba_q      <= '0;
      last_q     <= '0;
      rd_q       <= 1'b0;
      wr_q       <= 1'b0;
      loading_q  <= 1'b0;
      busy_q     <= 1'b0;
      dirty_q    <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      is_load_q  <= 1'b0;
      to_cnt_q   <= '0;
      idle_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      lba_q      <= lba_d;
      last_q     <= last_d;
      rd_q       <= rd_d;
      wr_q       <= wr_d;
      loading_q  <= loading_d;
      busy_q     <= busy_d;
      dirty_q    <= dirty_d;
      done_q     <= done_d;
      error_q    <= error_d;
      is_load_q  <= is_load_d;
      to_cnt_q   <= to_cnt_d;
      idle_cnt_q <= idle_cnt_d;
    end
    // Edge detectors track the inputs even in reset so release never fires a request
    old_load_q <= bus.load_req;
    old_save_q <= bus.save_req;
    old_ack_q  <= bus.sd_ack;
  end

  assign bus.sd_lba  = LBA_W'(lba_q);
  assign bus.sd_rd   = rd_q & reset;
  assign bus.sd_wr   = wr_q & reset;
  assign bus.loading = loading_q;
  assign bus.busy    = busy_q;
  assign bus.dirty   = dirty_q;
  assign bus.done    = done_q;
  assign bus.error   = error_q;

endmodule
`default_nettype wire

// File: tb/tb_bkram_sd_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_bkram_sd_ctrl : self-checking bench; plays hps_io (sector acks) and core.
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_bkram_sd_ctrl;

  localparam int ACK_TO  = 100;
  localparam int IDLE_TO = 50;
  localparam int MSB     = 7;

  typedef struct {
    logic [23:0] mask;
    bit          en;
    bit          ld;
    int          n_sect;
  } vec_t;

  logic clk_sys = 1'b0;
  logic reset;
  int   n_tests = 0;
  int   n_fail  = 0;
  bit   model_dirty;
  vec_t vecs[8];

  bkram_sd_ctrl_if #(.LBA_W(32)) bus ();

  bkram_sd_ctrl #(
    .LBA_W(32), .SECTOR_BITS(9), .MAX_SECT_BITS(MSB),
    .ACK_TIMEOUT(ACK_TO), .AUTOSAVE_IDLE(IDLE_TO)
  ) dut (
    .clk_sys(clk_sys),
    .reset  (reset),
    .bus    (bus)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Sector count from the mask: one sector per 512 bytes, capped at 2^MSB
  function automatic int model_sectors(input logic [23:0] mask, input bit en);
    int q;
    if (!en || mask == 24'd0) return 0;
    q = int'({8'd0, mask}) / 512;
    if (q > (1 << MSB) - 1) q = (1 << MSB) - 1;
    return q + 1;
  endfunction

  task automatic pulse_req(input bit ld);
    if (ld) bus.load_req = 1'b1;
    else    bus.save_req = 1'b1;
    tick();
    bus.load_req = 1'b0;
    bus.save_req = 1'b0;
  endtask

  task automatic wait_req(output bit found);
    found = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (bus.sd_rd || bus.sd_wr) begin
        found = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic expect_idle(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      check("no activity", 32'({bus.sd_rd, bus.sd_wr, bus.busy}), 32'd0);
    end
  endtask

  // hps_io side: serve n sectors, ack high for hi cycles, low at least lo cycles
  task automatic service(input bit ld, input int n, input int hi, input int lo,
                         input int dirty_at, input int stop_at);
    bit found;
    for (int s = 0; s < n; s++) begin
      wait_req(found);
      check("request seen", 32'(found), 32'd1);
      if (!found) return;
      check("sd_lba", bus.sd_lba, 32'(s));
      check("sd_rd", 32'(bus.sd_rd), 32'(ld));
      check("sd_wr", 32'(bus.sd_wr), 32'(!ld));
      check("loading", 32'(bus.loading), 32'(ld));
      check("busy in xfer", 32'(bus.busy), 32'd1);
      check("no early done", 32'(bus.done), 32'd0);
      if (s == stop_at) return;
      for (int i = 1; i < lo; i++) begin
        tick();
        check("request held", 32'(bus.sd_rd | bus.sd_wr), 32'd1);
      end
      bus.sd_ack = 1'b1;
      if (s == dirty_at) bus.dirty_wr = 1'b1;
      tick();
      bus.dirty_wr = 1'b0;
      check("request clears on ack", 32'({bus.sd_rd, bus.sd_wr}), 32'd0);
      for (int i = 1; i < hi; i++) tick();
      bus.sd_ack = 1'b0;
    end
    found = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      check("no extra sector", 32'(bus.sd_rd | bus.sd_wr), 32'd0);
      if (bus.done) begin
        found = 1'b1;
        break;
      end
    end
    check("done pulse", 32'(found), 32'd1);
    check("busy falls with done", 32'(bus.busy), 32'd0);
    check("loading low at done", 32'(bus.loading), 32'd0);
    tick();
    check("done single cycle", 32'(bus.done), 32'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: %0d comparisons made, expected run to complete", n_tests);
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit found;
    int k;
    logic [23:0] m;
    bit en, ld;
    int n, hi, lo;

    bus.ram_mask    = 24'd0;
    bus.enable      = 1'b1;
    bus.load_req    = 1'b0;
    bus.save_req    = 1'b0;
    bus.autoload    = 1'b0;
    bus.autosave_en = 1'b0;
    bus.dirty_wr    = 1'b0;
    bus.sd_ack      = 1'b0;
    reset           = 1'b0;
    repeat (3) tick();
    check("reset sd_lba", bus.sd_lba, 32'd0);
    check("reset sd_rd", 32'(bus.sd_rd), 32'd0);
    check("reset sd_wr", 32'(bus.sd_wr), 32'd0);
    check("reset loading", 32'(bus.loading), 32'd0);
    check("reset busy", 32'(bus.busy), 32'd0);
    check("reset dirty", 32'(bus.dirty), 32'd0);
    check("reset done", 32'(bus.done), 32'd0);
    check("reset error", 32'(bus.error), 32'd0);
    reset = 1'b1;
    tick();

    bus.dirty_wr = 1'b1;
    tick();
    bus.dirty_wr = 1'b0;
    model_dirty = 1'b1;

    vecs[0] = '{24'h000000, 1'b1, 1'b0, 0};
    vecs[1] = '{24'h0001FF, 1'b1, 1'b0, 1};
    vecs[2] = '{24'h000200, 1'b1, 1'b1, 2};
    vecs[3] = '{24'h001FFF, 1'b1, 1'b0, 16};
    vecs[4] = '{24'h0007FF, 1'b1, 1'b1, 4};
    vecs[5] = '{24'h001FFF, 1'b0, 1'b1, 0};
    vecs[6] = '{24'h001FFF, 1'b0, 1'b0, 0};
    vecs[7] = '{24'hFFFFFF, 1'b1, 1'b0, 128};
    foreach (vecs[i]) begin
      bus.ram_mask = vecs[i].mask;
      bus.enable   = vecs[i].en;
      tick();
      pulse_req(vecs[i].ld);
      if (vecs[i].n_sect == 0) begin
        expect_idle(10);
      end else begin
        service(vecs[i].ld, vecs[i].n_sect, 3, 2, -1, -1);
        model_dirty = 1'b0;
      end
      check("dirty after vector", 32'(bus.dirty), 32'(model_dirty));
    end

    // Autoload together with a load edge: one load only
    bus.ram_mask = 24'h0007FF;
    bus.enable   = 1'b1;
    tick();
    bus.autoload = 1'b1;
    bus.load_req = 1'b1;
    tick();
    bus.autoload = 1'b0;
    service(1'b1, 4, 3, 2, -1, -1);
    expect_idle(20);
    bus.load_req = 1'b0;
    tick();

    // Ack timeout on a save
    bus.ram_mask = 24'h001FFF;
    pulse_req(1'b0);
    check("timeout: wr at start", 32'(bus.sd_wr), 32'd1);
    repeat (ACK_TO - 1) tick();
    check("timeout: still waiting", 32'({bus.sd_wr, bus.busy, bus.error}), 32'b110);
    tick();
    check("timeout: wr", 32'(bus.sd_wr), 32'd0);
    check("timeout: busy", 32'(bus.busy), 32'd0);
    check("timeout: error", 32'(bus.error), 32'd1);
    check("timeout: dirty", 32'(bus.dirty), 32'd1);
    repeat (3) tick();
    check("error sticky", 32'(bus.error), 32'd1);
    bus.ram_mask = 24'h0003FF;
    pulse_req(1'b1);
    check("error cleared at load start", 32'(bus.error), 32'd0);
    service(1'b1, 2, 3, 2, -1, -1);
    check("dirty after load", 32'(bus.dirty), 32'd0);

    // Autosave after IDLE_TO quiet cycles following the last core write
    bus.autosave_en = 1'b1;
    bus.dirty_wr = 1'b1;
    tick();
    bus.dirty_wr = 1'b0;
    for (int i = 0; i < 19; i++) begin
      tick();
      check("no autosave yet", 32'(bus.sd_wr), 32'd0);
    end
    bus.dirty_wr = 1'b1;
    tick();
    bus.dirty_wr = 1'b0;
    k = 0;
    for (int i = 0; i < 200; i++) begin
      tick();
      k++;
      if (bus.sd_wr) break;
    end
    check("autosave delay", 32'(k), 32'(IDLE_TO + 1));
    bus.autosave_en = 1'b0;
    service(1'b0, 2, 3, 2, 0, -1);
    check("dirty kept by write during save", 32'(bus.dirty), 32'd1);
    model_dirty = 1'b1;

    // Randomized operations against the sector-count model
    for (int it = 0; it < 20; it++) begin
      if ($urandom_range(0, 5) == 0) m = 24'd0;
      else m = 24'(($urandom_range(0, 6) << 9) | $urandom_range(0, 511));
      en = ($urandom_range(0, 5) != 0);
      ld = ($urandom_range(0, 1) == 1);
      hi = int'($urandom_range(1, 4));
      lo = int'($urandom_range(1, 3));
      if ($urandom_range(0, 1) == 1) begin
        bus.dirty_wr = 1'b1;
        tick();
        bus.dirty_wr = 1'b0;
        model_dirty = 1'b1;
      end
      bus.ram_mask = m;
      bus.enable   = en;
      tick();
      check("rand dirty before", 32'(bus.dirty), 32'(model_dirty));
      n = model_sectors(m, en);
      pulse_req(ld);
      if (n == 0) begin
        expect_idle(4);
      end else begin
        service(ld, n, hi, lo, -1, -1);
        model_dirty = 1'b0;
      end
      check("rand dirty after", 32'(bus.dirty), 32'(model_dirty));
    end

    // Reset in the middle of a load, load_req held across release
    bus.ram_mask = 24'h001FFF;
    bus.enable   = 1'b1;
    tick();
    bus.load_req = 1'b1;
    tick();
    service(1'b1, 16, 2, 1, -1, 5);
    reset = 1'b0;
    #1;
    check("sd_rd drops with reset", 32'(bus.sd_rd), 32'd0);
    tick();
    check("mid reset sd_rd", 32'(bus.sd_rd), 32'd0);
    check("mid reset loading", 32'(bus.loading), 32'd0);
    check("mid reset sd_lba", bus.sd_lba, 32'd0);
    check("mid reset busy", 32'(bus.busy), 32'd0);
    tick();
    reset = 1'b1;
    expect_idle(20);
    bus.load_req = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
